led_shift_ctrl: RTL and testbench
=================================

LED_SHIFT_CTRL -- requirements
Module: led_shift_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 2: system-clock cycles per shift-clock half-period; legal range 1..255.
REQ-002 clock  input  1  system clock; all logic on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
REQ-004 data  input  8  byte to display; sampled only on an accepted transfer.
REQ-005 valid  input  1  upstream asserts when data is valid.
REQ-006 ready  output  1  high when the block can accept a byte.
REQ-007 sclk  output  1  shift clock to the downstream LED shift-register driver.
REQ-008 sdo  output  1  serial data to the driver, LSB first.
REQ-009 ltch  output  1  latch strobe to the driver; high transfers the shift register to the outputs; low enables shifting.
REQ-010 oe  output  1  output enable to the driver.
REQ-011 bright  input  4  brightness duty; present only when LED_PWM_EN is defined.

Function
REQ-012 States SHALL be IDLE, SHIFT and LATCH; all outputs SHALL be registered.
REQ-013 IDLE: ready=1, sclk=0, ltch=0; a transfer is accepted on the edge where valid=1 and ready=1; data is captured on that edge, and the state moves to SHIFT with ready=0 from the next cycle.
REQ-014 valid while ready=0 SHALL be ignored, with no capture and no queuing.
REQ-015 SHIFT: 8 bit windows, each 2*CLK_DIV cycles long; window i: sclk low for CLK_DIV cycles, then high for CLK_DIV cycles; sdo = captured bit i (i=0 first).
REQ-016 sdo SHALL change only on the first cycle of a window (sclk low) and SHALL stay stable through the sclk rising edge and high phase.
REQ-017 ltch SHALL be 0 throughout SHIFT.
REQ-018 After the 8th window (16*CLK_DIV cycles in SHIFT), the state SHALL move to LATCH with sclk=0; ltch=1 for exactly CLK_DIV cycles; sclk stays 0.
REQ-019 After LATCH, the state SHALL move to IDLE with ready=1; ready SHALL be low for exactly 17*CLK_DIV cycles per byte.
REQ-020 Back-to-back: valid held high SHALL be accepted on the first IDLE cycle, so there is one ready-high cycle between bytes.
REQ-021 A "shown" flag SHALL set at the end of the first LATCH state; oe SHALL be 0 while the flag is clear, which blanks power-up garbage.
REQ-022 Counters: 8-bit half-period counter and 3-bit bit index; the bit index SHALL wrap 7->0 only on the SHIFT->LATCH transition.

Reset
REQ-023 With rst_n=0 at an edge: state=IDLE, ready=0 during reset then 1 on the first cycle after release, sclk=0, sdo=0, ltch=0, oe=0, shown flag clear, counters 0, captured byte 0.
REQ-024 Reset during SHIFT or LATCH SHALL discard the byte with no ltch pulse; the next accepted byte is sent in full.

Configuration
REQ-025 Macro LED_PWM_EN.
- Defined: port bright exists; a free-running 4-bit counter runs 0..14 and wraps to 0 (period 15).
- bright is sampled when the counter wraps.
- oe = shown & (counter < sampled bright); bright=0 means always off, bright=15 means always on.
REQ-026 LED_PWM_EN undefined: no bright port, no PWM counter; oe = shown flag.

Verification
REQ-027 CLK_DIV=2, send 8'hA5 -> sdo sequence 1,0,1,0,0,1,0,1 sampled at sclk rises; 8 sclk pulses 2 cycles high; ltch high 2 cycles; ready low 34 cycles.
REQ-028 After reset, before any byte -> oe=0; after the first ltch falls -> oe=1 (PWM off), with the downstream driver model showing out=8'hA5.
REQ-029 valid held high, bytes 8'h01 then 8'h80 -> both accepted, exactly 1 ready-high cycle between them, final driver out=8'h80.
REQ-030 rst_n=0 at the 5th sclk rise of 8'hFF -> no ltch pulse, oe stays at its prior value of 0; then send 8'h3C -> driver out=8'h3C.
REQ-031 valid pulsed during SHIFT with 8'h00 -> ignored; the in-flight byte 8'hC3 is latched unchanged.
REQ-032 LED_PWM_EN, bright=4 -> oe high 4 of every 15 cycles; bright=0 -> oe always 0; bright=15 -> oe always 1; a bright change mid-period takes effect at the next wrap.

Source files
------------

// File: rtl/led_shift_ctrl.sv
// Byte-to-serial controller for a latching LED shift-register driver (LSB first).
// Optional brightness PWM on oe is enabled by defining LED_PWM_EN.
module led_shift_ctrl #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
`ifdef LED_PWM_EN
  input  logic [3:0] bright,
`endif
  output logic       ready,
  output logic       sclk,
  output logic       sdo,
  output logic       ltch,
  output logic       oe
);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

  state_t     state, state_nxt;
  logic [7:0] hcnt, hcnt_nxt;
  logic [2:0] bidx, bidx_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic       ready_nxt, sclk_nxt, sdo_nxt, ltch_nxt, oe_nxt;
  logic       shown, shown_nxt;

  always_comb begin
    state_nxt = state;
    hcnt_nxt  = hcnt;
    bidx_nxt  = bidx;
    shreg_nxt = shreg;
    ready_nxt = ready;
    sclk_nxt  = sclk;
    sdo_nxt   = sdo;
    ltch_nxt  = ltch;
    shown_nxt = shown;
    case (state)
      IDLE: begin
        sclk_nxt = 1'b0;
        ltch_nxt = 1'b0;
        hcnt_nxt = 8'd0;
        bidx_nxt = 3'd0;
        if (ready && valid) begin
          shreg_nxt = data;
          sdo_nxt   = data[0];
          ready_nxt = 1'b0;
          state_nxt = SHIFT;
        end else begin
          ready_nxt = 1'b1;
        end
      end
      SHIFT: begin
        if (hcnt == HALF_LAST) begin
          hcnt_nxt = 8'd0;
          if (!sclk) begin
            sclk_nxt = 1'b1;
          end else begin
            // End of a bit window: sdo only moves while sclk drops low.
            sclk_nxt = 1'b0;
            if (bidx == 3'd7) begin
              bidx_nxt  = 3'd0;
              ltch_nxt  = 1'b1;
              state_nxt = LATCH;
            end else begin
              bidx_nxt = bidx + 3'd1;
              sdo_nxt  = shreg[bidx_nxt];
            end
          end
        end else begin
          hcnt_nxt = hcnt + 8'd1;
        end
      end
      LATCH: begin
        if (hcnt == HALF_LAST) begin
          hcnt_nxt  = 8'd0;
          ltch_nxt  = 1'b0;
          ready_nxt = 1'b1;
          shown_nxt = 1'b1;
          state_nxt = IDLE;
        end else begin
          hcnt_nxt = hcnt + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef LED_PWM_EN
  logic [3:0] pwm_cnt, pwm_cnt_nxt;
  logic [3:0] bright_s, bright_s_nxt;

  // Period-15 counter; the new duty only applies from the wrap onward.
  always_comb begin
    pwm_cnt_nxt  = pwm_cnt + 4'd1;
    bright_s_nxt = bright_s;
    if (pwm_cnt == 4'd14) begin
      pwm_cnt_nxt  = 4'd0;
      bright_s_nxt = bright;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      pwm_cnt  <= 4'd0;
      bright_s <= 4'd0;
    end else begin
      pwm_cnt  <= pwm_cnt_nxt;
      bright_s <= bright_s_nxt;
    end
  end

  assign oe_nxt = shown_nxt & (pwm_cnt_nxt < bright_s_nxt);
`else
  assign oe_nxt = shown_nxt;
`endif

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state <= IDLE;
      hcnt  <= 8'd0;
      bidx  <= 3'd0;
      shreg <= 8'd0;
      ready <= 1'b0;
      sclk  <= 1'b0;
      sdo   <= 1'b0;
      ltch  <= 1'b0;
      shown <= 1'b0;
      oe    <= 1'b0;
    end else begin
      state <= state_nxt;
      hcnt  <= hcnt_nxt;
      bidx  <= bidx_nxt;
      shreg <= shreg_nxt;
      ready <= ready_nxt;
      sclk  <= sclk_nxt;
      sdo   <= sdo_nxt;
      ltch  <= ltch_nxt;
      shown <= shown_nxt;
      oe    <= oe_nxt;
    end
  end

endmodule

// File: tb/tb_led_shift_ctrl.sv
// Randomized bench for led_shift_ctrl: timeline reference model plus a
// downstream shift/latch driver model that reconstructs the displayed byte.
module tb_led_shift_ctrl;
  localparam int CD = 2;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] data  = 8'd0;
  logic       ready, sclk, sdo, ltch, oe;
`ifdef LED_PWM_EN
  logic [3:0] bright = 4'd15;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] drv_sr  = 8'd0;
  logic [7:0] drv_out = 8'd0;
  int         ltch_pulses = 0;
  bit         shown_exp = 1'b0;

  always #5 clock = ~clock;

  led_shift_ctrl #(.CLK_DIV(CD)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .data  (data),
    .valid (valid),
`ifdef LED_PWM_EN
    .bright(bright),
`endif
    .ready (ready),
    .sclk  (sclk),
    .sdo   (sdo),
    .ltch  (ltch),
    .oe    (oe)
  );

  // Downstream driver: LSB-first shift on sclk rise, copy to outputs on ltch.
  always @(posedge sclk) drv_sr <= {sdo, drv_sr[7:1]};
  always @(posedge ltch) begin
    drv_out     <= drv_sr;
    ltch_pulses <= ltch_pulses + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset(input int n);
    valid = 1'b0;
    rst_n = 1'b0;
    repeat (n) @(negedge clock);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_sclk",  32'(sclk),  32'd0);
    chk("rst_sdo",   32'(sdo),   32'd0);
    chk("rst_ltch",  32'(ltch),  32'd0);
    chk("rst_oe",    32'(oe),    32'd0);
    rst_n = 1'b1;
    shown_exp = 1'b0;
    @(negedge clock);
    chk("rdy_after_rst", 32'(ready), 32'd1);
  endtask

  // Drive one byte and compare every cycle of its transfer with the timeline
  // implied by the protocol: 8 windows of 2*CD, then CD cycles of latch.
  task automatic send(input logic [7:0] b, input bit hold, input int glitch_k);
    int n;
    bit got;
    data = b;
    valid = 1'b1;
    got = 1'b0;
    n = 0;
    while (!got && n < 100) begin
      if (ready) got = 1'b1;
      else begin
        @(negedge clock);
        n++;
      end
    end
    if (!got) begin
      chk("accept_timeout", 32'd0, 32'd1);
      valid = 1'b0;
      return;
    end
    @(negedge clock);
    if (!hold) valid = 1'b0;
    for (int k = 0; k < 17*CD; k++) begin
      if (k < 16*CD) begin
        chk("sclk", 32'(sclk), 32'((k % (2*CD)) >= CD));
        chk("sdo",  32'(sdo),  32'(b[k/(2*CD)]));
        chk("ltch", 32'(ltch), 32'd0);
      end else begin
        chk("sclk_latch", 32'(sclk), 32'd0);
        chk("ltch_latch", 32'(ltch), 32'd1);
      end
      chk("ready_busy", 32'(ready), 32'd0);
      chk("oe_busy",    32'(oe),    32'(shown_exp));
      if (k == glitch_k) begin
        data  = 8'h00;
        valid = 1'b1;
      end else if (glitch_k >= 0 && k == glitch_k + 1) begin
        data  = b;
        valid = hold;
      end
      @(negedge clock);
    end
    shown_exp = 1'b1;
    chk("ready_done", 32'(ready),   32'd1);
    chk("ltch_done",  32'(ltch),    32'd0);
    chk("sclk_done",  32'(sclk),    32'd0);
    chk("oe_done",    32'(oe),      32'd1);
    chk("drv_out",    32'(drv_out), 32'(b));
  endtask

  initial begin
    int pulses_before;
    logic [7:0] out_before;
    int rises, n;
    bit prev, hold, prev_hold;
    int glitch;
    logic [7:0] b;

    do_reset(3);
    chk("oe_before_first", 32'(oe), 32'd0);
    send(8'hA5, 1'b0, -1);
    chk("ltch_count_a5", 32'(ltch_pulses), 32'd1);

    // Abort a transfer mid-shift: no latch, oe stays blank, next byte whole.
    do_reset(2);
    pulses_before = ltch_pulses;
    out_before = drv_out;
    data = 8'hFF;
    valid = 1'b1;
    n = 0;
    while (!ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    valid = 1'b0;
    rises = 0;
    prev = sclk;
    n = 0;
    while (rises < 5 && n < 200) begin
      @(negedge clock);
      if (sclk && !prev) rises++;
      prev = sclk;
      n++;
    end
    chk("abort_rises", 32'(rises), 32'd5);
    rst_n = 1'b0;
    repeat (2) @(negedge clock);
    chk("abort_rst_ltch", 32'(ltch), 32'd0);
    chk("abort_rst_ready", 32'(ready), 32'd0);
    rst_n = 1'b1;
    shown_exp = 1'b0;
    repeat (2 * 17 * CD) @(negedge clock);
    chk("abort_no_pulse", 32'(ltch_pulses), 32'(pulses_before));
    chk("abort_oe",       32'(oe),          32'd0);
    chk("abort_out",      32'(drv_out),     32'(out_before));
    send(8'h3C, 1'b0, -1);

    // Back-to-back with valid held: one ready-high cycle between bytes.
    send(8'h01, 1'b1, -1);
    send(8'h80, 1'b0, -1);

    // valid pulsed with 0x00 while busy must be ignored.
    send(8'hC3, 1'b0, 10);

    prev_hold = 1'b0;
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom);
      hold = (i != 19) && ($urandom_range(0, 2) == 0);
      glitch = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 16*CD - 3)) : -1;
      if (!prev_hold) repeat ($urandom_range(0, 3)) @(negedge clock);
      send(b, hold, glitch);
      prev_hold = hold;
    end
    valid = 1'b0;

`ifdef LED_PWM_EN
    bright = 4'd4;
    repeat (40) @(negedge clock);
    n = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (oe) n++;
    end
    chk("pwm_duty4", 32'(n), 32'd4);
    bright = 4'd0;
    repeat (40) @(negedge clock);
    n = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (oe) n++;
    end
    chk("pwm_duty0", 32'(n), 32'd0);
    bright = 4'd15;
    repeat (40) @(negedge clock);
    n = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (oe) n++;
    end
    chk("pwm_duty15", 32'(n), 32'd15);
    bright = 4'd4;
    repeat (40) @(negedge clock);
    prev = oe;
    rises = 0;
    n = 0;
    while (rises == 0 && n < 40) begin
      @(negedge clock);
      if (oe && !prev) rises = 1;
      prev = oe;
      n++;
    end
    chk("pwm_wrap_found", 32'(rises), 32'd1);
    repeat (5) @(negedge clock);
    bright = 4'd15;
    chk("pwm_mid_hold", 32'(oe), 32'd0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      chk("pwm_mid_hold", 32'(oe), 32'd0);
    end
    @(negedge clock);
    chk("pwm_after_wrap", 32'(oe), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
